id_ex_stage_reg: RTL

- ID/EX pipeline register. Captures the decode-stage control bundle produced by MuxControl and the decode datapath values (PC, operands, immediate, destination), and presents them to EX one cycle later.
- Provides a real registered stall hold and a flush bubble, plus a valid bit.
- Provides a saturating bubble counter for performance debug.

---
 rtl/id_ex_pkg.sv | 28 ++
 rtl/id_ex_stage_reg_pipe_field_reg.sv | 27 ++
 rtl/id_ex_stage_reg.sv | 105 ++++++++++
 3 files changed

// File: rtl/id_ex_pkg.sv
// rtl/id_ex_pkg.sv - shared field widths and control bundle type for the ID/EX register
package id_ex_pkg;

    localparam int SOH_OP_W = 4;
    localparam int ALU_OP_W = 4;
    localparam int SIZE_W   = 2;
    localparam int ID_SR_W  = 3;

    typedef struct packed {
        logic [SOH_OP_W-1:0] soh_op;
        logic [ALU_OP_W-1:0] alu_op;
        logic                rw;
        logic                e;
        logic [SIZE_W-1:0]   size;
        logic                cc_we;
        logic                use_cc;
        logic                j_l;
        logic                call;
        logic                rf_le;
        logic [ID_SR_W-1:0]  id_sr;
        logic                b;
        logic                l;
    } ctrl_t;

    // All-zero control word is the NOP; MuxControl's flush path uses the same constant.
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_reg_pipe_field_reg.sv
// rtl/id_ex_stage_reg_pipe_field_reg.sv - one pipeline field: async clear, flush-to-zero, stall hold
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         stall,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (flush) begin
            r_q <= '0;
        end else if (!stall) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with stall hold, flush bubble and bubble counter
module id_ex_stage_reg
    import id_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                stall,
    input  logic                id_valid,
    input  logic [SOH_OP_W-1:0] id_soh_op,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_rw,
    input  logic                id_e,
    input  logic [SIZE_W-1:0]   id_size,
    input  logic                id_cc_we,
    input  logic                id_use_cc,
    input  logic                id_j_l,
    input  logic                id_call,
    input  logic                id_rf_le,
    input  logic [ID_SR_W-1:0]  id_id_sr,
    input  logic                id_b,
    input  logic                id_l,
    input  logic [DATA_W-1:0]   id_pc,
    input  logic [DATA_W-1:0]   id_opa,
    input  logic [DATA_W-1:0]   id_opb,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                cnt_clr,
    output logic [SOH_OP_W-1:0] ex_soh_op,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_rw,
    output logic                ex_e,
    output logic [SIZE_W-1:0]   ex_size,
    output logic                ex_cc_we,
    output logic                ex_use_cc,
    output logic                ex_j_l,
    output logic                ex_call,
    output logic                ex_rf_le,
    output logic [ID_SR_W-1:0]  ex_id_sr,
    output logic                ex_b,
    output logic                ex_l,
    output logic [DATA_W-1:0]   ex_pc,
    output logic [DATA_W-1:0]   ex_opa,
    output logic [DATA_W-1:0]   ex_opb,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                ex_valid,
    output logic [CNT_W-1:0]    bubble_cnt
);

    ctrl_t            w_id_ctrl;
    ctrl_t            w_ex_ctrl;
    logic [CNT_W-1:0] r_bubble_cnt;

    assign w_id_ctrl = '{soh_op: id_soh_op, alu_op: id_alu_op, rw: id_rw, e: id_e,
                         size: id_size, cc_we: id_cc_we, use_cc: id_use_cc, j_l: id_j_l,
                         call: id_call, rf_le: id_rf_le, id_sr: id_id_sr, b: id_b, l: id_l};

    pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .d(w_id_ctrl), .q(w_ex_ctrl));
    pipe_field_reg #(.W(1)) u_valid (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .d(id_valid), .q(ex_valid));
    pipe_field_reg #(.W(DATA_W)) u_pc (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .d(id_pc), .q(ex_pc));
    pipe_field_reg #(.W(DATA_W)) u_opa (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .d(id_opa), .q(ex_opa));
    pipe_field_reg #(.W(DATA_W)) u_opb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .d(id_opb), .q(ex_opb));
    pipe_field_reg #(.W(DATA_W)) u_imm (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .d(id_imm), .q(ex_imm));
    pipe_field_reg #(.W(REG_AW)) u_rd (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .d(id_rd), .q(ex_rd));

    assign ex_soh_op = w_ex_ctrl.soh_op;
    assign ex_alu_op = w_ex_ctrl.alu_op;
    assign ex_rw     = w_ex_ctrl.rw;
    assign ex_e      = w_ex_ctrl.e;
    assign ex_size   = w_ex_ctrl.size;
    assign ex_cc_we  = w_ex_ctrl.cc_we;
    assign ex_use_cc = w_ex_ctrl.use_cc;
    assign ex_j_l    = w_ex_ctrl.j_l;
    assign ex_call   = w_ex_ctrl.call;
    assign ex_rf_le  = w_ex_ctrl.rf_le;
    assign ex_id_sr  = w_ex_ctrl.id_sr;
    assign ex_b      = w_ex_ctrl.b;
    assign ex_l      = w_ex_ctrl.l;

    // Counts flush bubbles regardless of stall; clear wins over a same-edge flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (cnt_clr) begin
            r_bubble_cnt <= '0;
        end else if (flush && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule
